// File: rtl/wb_regfile.sv
`default_nettype none
// ============================================================================
// Module      : wb_regfile
// Description : Writeback stage register file. Forms the writeback value from
//               the MEM/WB controls, commits it to a 32-entry GPR file with r0
//               hardwired to zero, and keeps a commit counter and a record of
//               the last write for debug/trace.
//               Optional macro REG_BYPASS_EN: write-through on the read ports.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_regfile #(
  parameter int DATA_W   = 32,
  parameter int NREG     = 32,
  parameter int ADDR_W   = 5,
  parameter int LINK_OFS = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWr,
  input  logic [1:0]        RegDst,
  input  logic [1:0]        Digit,
  input  logic              LoadUnsigned,
  input  logic              immres,
  input  logic [1:0]        cmp,
  input  logic [ADDR_W-1:0] WbAddr,
  input  logic [DATA_W-1:0] AluOutput,
  input  logic [DATA_W-1:0] MemRdata,
  input  logic [DATA_W-1:0] PC,
  input  logic [DATA_W-1:0] extend,
  input  logic [ADDR_W-1:0] RsAddr,
  input  logic [ADDR_W-1:0] RtAddr,
  output logic [DATA_W-1:0] RsData,
  output logic [DATA_W-1:0] RtData,
  output logic [31:0]       WrCount,
  output logic [ADDR_W-1:0] LastAddr,
  output logic [DATA_W-1:0] LastData
);

  localparam logic [1:0] C_SRC_ALU  = 2'b00;
  localparam logic [1:0] C_SRC_LOAD = 2'b01;
  localparam logic [1:0] C_SRC_LINK = 2'b10;
  localparam logic [1:0] C_SZ_HALF  = 2'b01;
  localparam logic [1:0] C_SZ_BYTE  = 2'b10;
  localparam logic [1:0] C_CMP_LT   = 2'b01;
  localparam logic [1:0] C_CMP_EQ   = 2'b10;

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic [31:0]       wr_count_q, wr_count_d;
  logic [ADDR_W-1:0] last_addr_q, last_addr_d;
  logic [DATA_W-1:0] last_data_q, last_data_d;

  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [DATA_W-1:0] w_load;
  logic              w_flag;
  logic [DATA_W-1:0] w_wdata;
  logic              w_commit;

  // Load lane extraction: byte lane from addr[1:0], half lane from addr[1].
  always_comb begin
    w_byte = 8'h00;
    case (AluOutput[1:0])
      2'b00:   w_byte = MemRdata[7:0];
      2'b01:   w_byte = MemRdata[15:8];
      2'b10:   w_byte = MemRdata[23:16];
      default: w_byte = MemRdata[31:24];
    endcase
    w_half = AluOutput[1] ? MemRdata[31:16] : MemRdata[15:0];

    w_load = MemRdata;
    if (Digit == C_SZ_BYTE) begin
      w_load = {{(DATA_W-8){~LoadUnsigned & w_byte[7]}}, w_byte};
    end else if (Digit == C_SZ_HALF) begin
      w_load = {{(DATA_W-16){~LoadUnsigned & w_half[15]}}, w_half};
    end
  end

  always_comb begin
    w_flag = 1'b0;
    case (cmp)
      C_CMP_LT: w_flag = AluOutput[DATA_W-1];
      C_CMP_EQ: w_flag = (AluOutput == '0);
      default:  w_flag = 1'b0;
    endcase
  end

  always_comb begin
    w_wdata = AluOutput;
    if (immres) begin
      w_wdata = extend;
    end else begin
      case (RegDst)
        C_SRC_ALU:  w_wdata = AluOutput;
        C_SRC_LOAD: w_wdata = w_load;
        C_SRC_LINK: w_wdata = PC + DATA_W'(LINK_OFS);
        default:    w_wdata = {{(DATA_W-1){1'b0}}, w_flag};
      endcase
    end
  end

  assign w_commit = RegWr && (WbAddr != '0);

  always_comb begin
    regs_d      = regs_q;
    wr_count_d  = wr_count_q;
    last_addr_d = last_addr_q;
    last_data_d = last_data_q;
    if (w_commit) begin
      regs_d[WbAddr] = w_wdata;
      wr_count_d     = wr_count_q + 32'd1;
      last_addr_d    = WbAddr;
      last_data_d    = w_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      wr_count_q  <= '0;
      last_addr_q <= '0;
      last_data_q <= '0;
    end else begin
      regs_q      <= regs_d;
      wr_count_q  <= wr_count_d;
      last_addr_q <= last_addr_d;
      last_data_q <= last_data_d;
    end
  end

  // r0 is never written, but reads of address 0 are forced to zero regardless.
  always_comb begin
    RsData = (RsAddr == '0) ? '0 : regs_q[RsAddr];
    RtData = (RtAddr == '0) ? '0 : regs_q[RtAddr];
`ifdef REG_BYPASS_EN
    if (w_commit && (RsAddr == WbAddr)) RsData = w_wdata;
    if (w_commit && (RtAddr == WbAddr)) RtData = w_wdata;
`endif
  end

  assign WrCount  = wr_count_q;
  assign LastAddr = last_addr_q;
  assign LastData = last_data_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_regfile.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_regfile
// Description : Scoreboard bench for wb_regfile: directed writeback vectors
//               push expected outputs, a negedge monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_regfile;

  localparam int K_RS  = 0;
  localparam int K_RT  = 1;
  localparam int K_CNT = 2;
  localparam int K_LA  = 3;
  localparam int K_LD  = 4;

  typedef struct {
    int          kind;
    int          tag;
    logic [31:0] exp;
  } sb_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        RegWr;
  logic [1:0]  RegDst, Digit, cmp;
  logic        LoadUnsigned, immres;
  logic [4:0]  WbAddr, RsAddr, RtAddr;
  logic [31:0] AluOutput, MemRdata, PC, extend;
  logic [31:0] RsData, RtData, WrCount, LastData;
  logic [4:0]  LastAddr;

  sb_t         sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          tag   = 0;
  logic [31:0] e_cnt = 0;
  logic [4:0]  e_la  = 0;
  logic [31:0] e_ld  = 0;
  logic        bypass;

  wb_regfile dut (
    .clk(clk), .reset(reset), .RegWr(RegWr), .RegDst(RegDst), .Digit(Digit),
    .LoadUnsigned(LoadUnsigned), .immres(immres), .cmp(cmp), .WbAddr(WbAddr),
    .AluOutput(AluOutput), .MemRdata(MemRdata), .PC(PC), .extend(extend),
    .RsAddr(RsAddr), .RtAddr(RtAddr), .RsData(RsData), .RtData(RtData),
    .WrCount(WrCount), .LastAddr(LastAddr), .LastData(LastData)
  );

  always #5 clk = ~clk;

  // Monitor: outputs are stable at negedge, half a cycle after stimulus.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      sb_t         e;
      logic [31:0] act;
      e = sb.pop_front();
      case (e.kind)
        K_RS:    act = RsData;
        K_RT:    act = RtData;
        K_CNT:   act = WrCount;
        K_LA:    act = {27'b0, LastAddr};
        default: act = LastData;
      endcase
      n_cmp++;
      if (act !== e.exp) begin
        n_bad++;
        $display("FAIL chk%0d kind%0d actual=%08h required=%08h", e.tag, e.kind, act, e.exp);
      end
    end
  end

  task automatic push(input int kind, input logic [31:0] exp);
    sb_t e;
    e.kind = kind;
    e.tag  = tag;
    e.exp  = exp;
    sb.push_back(e);
    tag++;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_status();
    push(K_CNT, e_cnt);
    push(K_LA, {27'b0, e_la});
    push(K_LD, e_ld);
  endtask

  task automatic drive(input logic [4:0] a, input logic [1:0] dst, input logic [1:0] dig,
                       input logic lu, input logic imm, input logic [1:0] c,
                       input logic [31:0] alu, input logic [31:0] mem,
                       input logic [31:0] pc, input logic [31:0] ext);
    RegWr = 1'b1; WbAddr = a; RegDst = dst; Digit = dig; LoadUnsigned = lu;
    immres = imm; cmp = c; AluOutput = alu; MemRdata = mem; PC = pc; extend = ext;
  endtask

  // Commit one write, then read back the destination and the trace state.
  task automatic wr(input logic [4:0] a, input logic [1:0] dst, input logic [1:0] dig,
                    input logic lu, input logic imm, input logic [1:0] c,
                    input logic [31:0] alu, input logic [31:0] mem,
                    input logic [31:0] pc, input logic [31:0] ext,
                    input logic [31:0] expv);
    drive(a, dst, dig, lu, imm, c, alu, mem, pc, ext);
    cyc();
    RegWr = 1'b0;
    if (a != 5'd0) begin
      e_cnt++;
      e_la = a;
      e_ld = expv;
    end
    RtAddr = a;
    push(K_RT, (a == 5'd0) ? 32'd0 : expv);
    push_status();
    cyc();
  endtask

  initial begin
`ifdef REG_BYPASS_EN
    bypass = 1'b1;
`else
    bypass = 1'b0;
`endif
    reset = 1'b1; RegWr = 1'b0; RegDst = 2'b00; Digit = 2'b00; cmp = 2'b00;
    LoadUnsigned = 1'b0; immres = 1'b0; WbAddr = 5'd0; RsAddr = 5'd0; RtAddr = 5'd0;
    AluOutput = 32'd0; MemRdata = 32'd0; PC = 32'd0; extend = 32'd0;
    cyc();
    RsAddr = 5'd0;
    push(K_RS, 32'd0);
    push_status();
    cyc();
    reset = 1'b0;

    for (int i = 1; i < 32; i++) begin
      RsAddr = 5'(i);
      RtAddr = 5'(32 - i);
      push(K_RS, 32'd0);
      push(K_RT, 32'd0);
      cyc();
    end
    push_status();
    cyc();

    wr(5'd5,  2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 32'h12345678, 32'h0, 32'h0, 32'h0, 32'h12345678);
    // Sub-word loads from MemRdata = 0x80FFFFFF
    wr(5'd1,  2'b01, 2'b10, 1'b0, 1'b0, 2'b00, 32'h00000003, 32'h80FFFFFF, 32'h0, 32'h0, 32'hFFFFFF80);
    wr(5'd2,  2'b01, 2'b10, 1'b1, 1'b0, 2'b00, 32'h00000003, 32'h80FFFFFF, 32'h0, 32'h0, 32'h00000080);
    wr(5'd3,  2'b01, 2'b01, 1'b0, 1'b0, 2'b00, 32'h00000002, 32'h80FFFFFF, 32'h0, 32'h0, 32'hFFFF80FF);
    wr(5'd4,  2'b01, 2'b11, 1'b0, 1'b0, 2'b00, 32'h00000003, 32'h80FFFFFF, 32'h0, 32'h0, 32'h80FFFFFF);
    wr(5'd6,  2'b01, 2'b00, 1'b1, 1'b0, 2'b00, 32'h00000001, 32'h80FFFFFF, 32'h0, 32'h0, 32'h80FFFFFF);
    wr(5'd17, 2'b01, 2'b10, 1'b1, 1'b0, 2'b00, 32'h00000001, 32'h80FFA5FF, 32'h0, 32'h0, 32'h000000A5);
    wr(5'd18, 2'b01, 2'b01, 1'b1, 1'b0, 2'b00, 32'h00000000, 32'h1234C001, 32'h0, 32'h0, 32'h0000C001);
    // Link: wraps, and a non-wrapping case
    wr(5'd8,  2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 32'h00000055, 32'h0, 32'h0, 32'h0, 32'h00000055);
    wr(5'd8,  2'b10, 2'b00, 1'b0, 1'b0, 2'b00, 32'h00000055, 32'h0, 32'hFFFFFFFC, 32'h0, 32'h00000000);
    wr(5'd10, 2'b10, 2'b00, 1'b0, 1'b0, 2'b00, 32'h00000000, 32'h0, 32'h00001000, 32'h0, 32'h00001004);
    // immres overrides RegDst
    wr(5'd11, 2'b01, 2'b10, 1'b0, 1'b1, 2'b00, 32'h00000003, 32'h80FFFFFF, 32'h0, 32'h0000ABCD, 32'h0000ABCD);
    wr(5'd12, 2'b10, 2'b00, 1'b0, 1'b1, 2'b01, 32'h80000000, 32'h0, 32'h100, 32'h0000ABCD, 32'h0000ABCD);
    // Compare flags
    wr(5'd13, 2'b11, 2'b00, 1'b0, 1'b0, 2'b01, 32'h80000000, 32'h0, 32'h0, 32'h0, 32'h00000001);
    wr(5'd14, 2'b11, 2'b00, 1'b0, 1'b0, 2'b10, 32'h00000000, 32'h0, 32'h0, 32'h0, 32'h00000001);
    wr(5'd15, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 32'h000000FF, 32'h0, 32'h0, 32'h0, 32'h000000FF);
    wr(5'd15, 2'b11, 2'b00, 1'b0, 1'b0, 2'b10, 32'h00000005, 32'h0, 32'h0, 32'h0, 32'h00000000);
    wr(5'd16, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 32'h000000FF, 32'h0, 32'h0, 32'h0, 32'h000000FF);
    wr(5'd16, 2'b11, 2'b00, 1'b0, 1'b0, 2'b00, 32'h80000000, 32'h0, 32'h0, 32'h0, 32'h00000000);
    wr(5'd19, 2'b11, 2'b00, 1'b0, 1'b0, 2'b11, 32'h00000000, 32'h0, 32'h0, 32'h0, 32'h00000000);
    wr(5'd20, 2'b11, 2'b00, 1'b0, 1'b0, 2'b01, 32'h7FFFFFFF, 32'h0, 32'h0, 32'h0, 32'h00000000);
    // Write to r0 discarded
    wr(5'd0,  2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0, 32'hDEADBEEF);

    // RegWr=0: nothing changes
    RegWr = 1'b0; WbAddr = 5'd5; RegDst = 2'b00; immres = 1'b0; AluOutput = 32'hBAD0BAD0;
    RtAddr = 5'd5;
    push(K_RT, 32'h12345678);
    cyc();
    push(K_RT, 32'h12345678);
    push_status();
    cyc();

    // Same-cycle read of the register being written
    drive(5'd7, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 32'hCAFEF00D, 32'h0, 32'h0, 32'h0);
    RsAddr = 5'd7;
    RtAddr = 5'd7;
    push(K_RS, bypass ? 32'hCAFEF00D : 32'h0);
    push(K_RT, bypass ? 32'hCAFEF00D : 32'h0);
    cyc();
    RegWr = 1'b0;
    e_cnt++; e_la = 5'd7; e_ld = 32'hCAFEF00D;
    push(K_RS, 32'hCAFEF00D);
    push(K_RT, 32'hCAFEF00D);
    push_status();
    cyc();

    // Asynchronous reset between edges with a write pending
    drive(5'd9, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 32'h99999999, 32'h0, 32'h0, 32'h0);
    #2;
    reset = 1'b1;
    e_cnt = 0; e_la = 5'd0; e_ld = 32'd0;
    RsAddr = 5'd7;
    RtAddr = 5'd5;
    push(K_RS, 32'd0);
    push(K_RT, 32'd0);
    push_status();
    cyc();
    RtAddr = 5'd9;
    push(K_RT, 32'd0);
    push_status();
    cyc();
    reset = 1'b0;
    RegWr = 1'b0;
    push(K_RT, 32'd0);
    push_status();
    cyc();
    wr(5'd21, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 32'h00C0FFEE, 32'h0, 32'h0, 32'h0, 32'h00C0FFEE);

    repeat (2) cyc();

    RegWr  = 1'b0;
    RsAddr = 5'd21;
    RtAddr = 5'd21;
    #1;
    n_cmp++;
    if (RsData !== 32'h00C0FFEE) begin
      n_bad++;
      $display("FAIL final RsData actual=%08h required=%08h", RsData, 32'h00C0FFEE);
    end
    n_cmp++;
    if (RtData !== 32'h00C0FFEE) begin
      n_bad++;
      $display("FAIL final RtData actual=%08h required=%08h", RtData, 32'h00C0FFEE);
    end
    n_cmp++;
    if (WrCount !== e_cnt) begin
      n_bad++;
      $display("FAIL final WrCount actual=%08h required=%08h", WrCount, e_cnt);
    end
    n_cmp++;
    if (LastAddr !== 5'd21) begin
      n_bad++;
      $display("FAIL final LastAddr actual=%0d required=%0d", LastAddr, 21);
    end
    n_cmp++;
    if (LastData !== 32'h00C0FFEE) begin
      n_bad++;
      $display("FAIL final LastData actual=%08h required=%08h", LastData, 32'h00C0FFEE);
    end

    while (sb.size() > 0) begin
      sb_t e;
      e = sb.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL chk%0d never compared required=%08h", e.tag, e.exp);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
